imem_fetch_seq: RTL and testbench
=================================

Name: imem_fetch_seq

Overview:
- Instruction-fetch sequencer for the single-cycle MIPS core. Owns the PC and drives the combinational 32-word instruction ROM address (word index = Addr[6:2]).
- Selects the next PC from sequential, branch (beq/bne taken) and jump sources.
- Honours stall and halt requests, and faults when the PC would leave the populated ROM window.
- Gates the fetched word and flags whether it is valid for decode.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
IMEM_WORDS, 32, number of ROM words; legal PC range is 0 .. 4*IMEM_WORDS-4

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
Stall  in  1  hold PC this cycle
Branch  in  1  taken branch, resolved this cycle
BranchOff  in  16  signed word offset (imm16)
Jump  in  1  J-type jump
JumpIdx  in  26  jump word index
Halt  in  1  external halt request
ImemAddr  out  32  address to instruction ROM; equals PC
ImemInst  in  32  word returned by ROM (combinational)
Inst  out  32  ImemInst when InstValid=1, else 32'h0
InstValid  out  1  Inst is a legal instruction for decode
PC  out  32  current PC
PCPlus4  out  32  PC+4
State  out  2  00 BOOT, 01 RUN, 10 HALT
Fault  out  2  00 none, 01 PC out of range, 10 external halt
RetiredCnt  out  16  instructions retired, saturating

Behaviour:
Reset values (synchronous; Reset wins over all other inputs on the same edge):
- PC=RESET_PC, State=BOOT, InstValid=0, Inst=0, Fault=00, RetiredCnt=0.

BOOT:
- Lasts exactly one cycle after Reset deasserts. PC holds.
- Next state RUN, unconditionally, unless Halt=1, which goes to HALT with Fault=10.

RUN:
- InstValid=1.
- Next-PC candidates:
  - seq = PC+4
  - br = PC+4 + (sign-extended BranchOff << 2), mod 2^32
  - jmp = {PCPlus4[31:28], JumpIdx, 2'b00}
- Priority, highest first: Halt > Stall > Jump > Branch > seq.
- Halt=1: go to HALT, Fault=10, PC holds. The current instruction does not retire.
- Stall=1: PC holds. Branch and Jump are ignored that cycle; the source re-asserts them. RetiredCnt does not increment.
- Range check: if the selected next PC is >= 4*IMEM_WORDS (including wrap past 0xFFFFFFFF), go to HALT with Fault=01.
  - PC holds at the faulting instruction's address.
  - That instruction counts as retired.
- Otherwise PC <= selected next PC and RetiredCnt increments, saturating at 16'hFFFF.
- Next-PC low 2 bits are always 00 by construction; no misalignment fault exists.

HALT:
- InstValid=0, Inst=0, PC frozen, Fault latched.
- All inputs except Reset are ignored. Only Reset exits.
- Fault is never overwritten while in HALT; the first cause wins.

Timing and latency:
- ImemAddr=PC with zero latency. Inst is combinational from ImemInst, gated by InstValid.
- All state updates occur on the Clk rising edge.
- One instruction retires per non-stalled RUN cycle.

Reset mid-operation:
- Reset in any state, including during Stall or HALT, restores the reset values on the next edge.
- The BOOT cycle then repeats.

Test Plan:
1. Reset: hold Reset for 2 cycles, then release. Cycle 1: State=00, InstValid=0, Inst=0. Cycle 2: State=01, PC=0, Inst=32'h20010008, InstValid=1, RetiredCnt=0.
2. Stall: at PC=0x08, hold Stall=1 for 3 cycles with Branch=1 held as well. PC stays 0x08 and RetiredCnt is unchanged. Release both: PC goes to 0x0C.
3. Branch and jump:
   - At PC=0x18, Branch=1, BranchOff=16'h0002: next PC=0x24.
   - At PC=0x28, Jump=1, JumpIdx=26'h000000D: next PC=0x34.
   - At PC=0x3C, Jump=1 and Branch=1 together, BranchOff=16'h0003, JumpIdx=26'h0000013: next PC=0x4C (jump wins).
4. Negative offsets:
   - At PC=0x3C, Branch=1, BranchOff=16'hFFFC: next PC=0x30.
   - At PC=0x04, BranchOff=16'hFFFD: target wraps to 0xFFFFFFFC, giving State=10, Fault=01, PC=0x04.
5. Range fault: run sequentially to PC=0x7C and step once. Result: State=10, Fault=01, PC=0x7C, InstValid=0, RetiredCnt incremented. A later Halt=1 leaves Fault=01.
6. Halt and recovery:
   - At PC=0x10, assert Halt=1 together with Stall=1: State=10, Fault=10, PC=0x10, RetiredCnt unchanged.
   - Then assert Reset for 1 cycle: State=00, Fault=00, PC=0.

Source files
------------

// File: rtl/imem_fetch_seq_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_seq_if
// Bundles the fetch sequencer's control, ROM and status signals.
//   master : environment side (drives Stall/Branch/Jump/Halt requests and the
//            combinational ROM word ImemInst; observes all sequencer outputs)
//   slave  : sequencer side (imem_fetch_seq)
// Signals:
//   Stall, Branch, BranchOff[15:0], Jump, JumpIdx[25:0], Halt  - requests
//   ImemAddr[31:0] / ImemInst[31:0]                            - ROM port
//   Inst[31:0], InstValid                                      - decode feed
//   PC[31:0], PCPlus4[31:0], State[1:0], Fault[1:0],
//   RetiredCnt[15:0]                                           - status
// ---------------------------------------------------------------------------
interface imem_fetch_seq_if;
   logic        Stall;
   logic        Branch;
   logic [15:0] BranchOff;
   logic        Jump;
   logic [25:0] JumpIdx;
   logic        Halt;
   logic [31:0] ImemAddr;
   logic [31:0] ImemInst;
   logic [31:0] Inst;
   logic        InstValid;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic [1:0]  State;
   logic [1:0]  Fault;
   logic [15:0] RetiredCnt;

   modport master (
      output Stall, Branch, BranchOff, Jump, JumpIdx, Halt, ImemInst,
      input  ImemAddr, Inst, InstValid, PC, PCPlus4, State, Fault, RetiredCnt
   );

   modport slave (
      input  Stall, Branch, BranchOff, Jump, JumpIdx, Halt, ImemInst,
      output ImemAddr, Inst, InstValid, PC, PCPlus4, State, Fault, RetiredCnt
   );
endinterface

// File: rtl/imem_fetch_seq.sv
// ---------------------------------------------------------------------------
// imem_fetch_seq
// Instruction-fetch sequencer for the single-cycle MIPS core. Owns the PC,
// addresses the combinational instruction ROM, selects the next PC from
// sequential / branch / jump sources, honours stall and halt, and faults when
// the PC would leave the populated ROM window.
// Ports:
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high reset (wins over every other input)
//   bus   : imem_fetch_seq_if.slave (requests, ROM port, decode feed, status)
// Parameters:
//   RESET_PC   : PC loaded on reset
//   IMEM_WORDS : ROM depth; legal PC range is 0 .. 4*IMEM_WORDS-4
// ---------------------------------------------------------------------------
module imem_fetch_seq #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 32
) (
   input logic              Clk,
   input logic              Reset,
   imem_fetch_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      BOOT = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      F_NONE  = 2'b00,
      F_RANGE = 2'b01,
      F_HALT  = 2'b10
   } fault_e;

   localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

   state_e      state_q;
   fault_e      fault_q;
   logic [31:0] pc_q;
   logic [15:0] ret_q;
   logic        valid_q;

   logic [31:0] pc_plus4;
   logic [31:0] br_tgt;
   logic [31:0] jmp_tgt;
   logic [31:0] npc_d;
   logic        npc_oor;
   logic [15:0] ret_d;

   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      // Sign-extended word offset; the add wraps mod 2^32, so a negative
      // target below zero lands high and is caught by the range check.
      br_tgt   = pc_plus4 + {{14{bus.BranchOff[15]}}, bus.BranchOff, 2'b00};
      jmp_tgt  = {pc_plus4[31:28], bus.JumpIdx, 2'b00};
      npc_d    = pc_plus4;
      if (bus.Jump) begin
         npc_d = jmp_tgt;
      end else if (bus.Branch) begin
         npc_d = br_tgt;
      end
      npc_oor  = (npc_d >= PC_LIMIT);
      ret_d    = (ret_q == '1) ? ret_q : ret_q + 16'd1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= BOOT;
         fault_q <= F_NONE;
         pc_q    <= RESET_PC;
         ret_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            BOOT: begin
               if (bus.Halt) begin
                  state_q <= HALT;
                  fault_q <= F_HALT;
                  valid_q <= 1'b0;
               end else begin
                  state_q <= RUN;
                  valid_q <= 1'b1;
               end
            end
            RUN: begin
               if (bus.Halt) begin
                  state_q <= HALT;
                  fault_q <= F_HALT;
                  valid_q <= 1'b0;
               end else if (!bus.Stall) begin
                  // The faulting instruction itself still retires; only the
                  // PC update is suppressed so it stays at the culprit.
                  ret_q <= ret_d;
                  if (npc_oor) begin
                     state_q <= HALT;
                     fault_q <= F_RANGE;
                     valid_q <= 1'b0;
                  end else begin
                     pc_q <= npc_d;
                  end
               end
            end
            HALT: begin
               valid_q <= 1'b0;
            end
            default: begin
               state_q <= HALT;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ImemAddr   = pc_q;
   assign bus.PC         = pc_q;
   assign bus.PCPlus4    = pc_plus4;
   assign bus.State      = state_q;
   assign bus.Fault      = fault_q;
   assign bus.RetiredCnt = ret_q;
   assign bus.InstValid  = valid_q;
   assign bus.Inst       = valid_q ? bus.ImemInst : '0;

endmodule

// File: tb/tb_imem_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_seq
// Self-checking bench for imem_fetch_seq: a behavioural model tracks the
// architectural PC / mode / fault / retired count and a negedge process
// compares every DUT output against it; directed sequences pin literal values.
// ---------------------------------------------------------------------------
module tb_imem_fetch_seq;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int unsigned WORDS  = 32;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   imem_fetch_seq_if bus ();

   imem_fetch_seq #(
      .RESET_PC   (RST_PC),
      .IMEM_WORDS (WORDS)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   logic [31:0] rom [32];
   assign bus.ImemInst = rom[bus.ImemAddr[6:2]];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 boot, 1 run, 2 halt (same meaning as the State output)
   bit          m_ok = 1'b0;
   int          m_mode;
   logic [31:0] m_pc;
   logic [1:0]  m_fault;
   int unsigned m_ret;

   function automatic logic [31:0] target(input logic [31:0] pc, input bit j,
                                          input logic [25:0] idx, input bit b,
                                          input logic [15:0] off);
      longint p4 = longint'(pc) + 4;
      if (j) return 32'((p4 & 64'h0000_0000_F000_0000) + longint'(idx) * 4);
      if (b) return 32'(p4 + 4 * longint'($signed(off)));
      return 32'(p4);
   endfunction

   always @(posedge Clk) begin
      if (Reset) begin
         m_ok    <= 1'b1;
         m_mode  <= 0;
         m_pc    <= RST_PC;
         m_fault <= 2'd0;
         m_ret   <= 0;
      end else if (m_ok) begin
         if (m_mode == 0) begin
            if (bus.Halt) begin
               m_mode  <= 2;
               m_fault <= 2'd2;
            end else begin
               m_mode <= 1;
            end
         end else if (m_mode == 1) begin
            if (bus.Halt) begin
               m_mode  <= 2;
               m_fault <= 2'd2;
            end else if (!bus.Stall) begin
               m_ret <= (m_ret >= 65535) ? 65535 : m_ret + 1;
               if (target(m_pc, bus.Jump, bus.JumpIdx, bus.Branch, bus.BranchOff) >= 4 * WORDS) begin
                  m_mode  <= 2;
                  m_fault <= 2'd1;
               end else begin
                  m_pc <= target(m_pc, bus.Jump, bus.JumpIdx, bus.Branch, bus.BranchOff);
               end
            end
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge Clk) begin
      if (m_ok) begin
         check("PC", bus.PC, m_pc);
         check("ImemAddr", bus.ImemAddr, m_pc);
         check("PCPlus4", bus.PCPlus4, m_pc + 32'd4);
         check("State", 32'(bus.State), 32'(m_mode));
         check("Fault", 32'(bus.Fault), 32'(m_fault));
         check("RetiredCnt", 32'(bus.RetiredCnt), m_ret);
         check("InstValid", 32'(bus.InstValid), (m_mode == 1) ? 32'd1 : 32'd0);
         check("Inst", bus.Inst, (m_mode == 1) ? rom[(m_pc / 4) % 32] : 32'h0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit s, input bit b, input logic [15:0] off,
                        input bit j, input logic [25:0] idx, input bit h);
      bus.Stall     = s;
      bus.Branch    = b;
      bus.BranchOff = off;
      bus.Jump      = j;
      bus.JumpIdx   = idx;
      bus.Halt      = h;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge Clk);
         #1;
      end
   endtask

   initial begin
      rom[0] = 32'h2001_0008;
      for (int unsigned i = 1; i < 32; i++) rom[i] = {8'hA5, 8'(i), 16'(i * 37 + 3)};
      idle();

      // Reset and boot
      Reset = 1'b1;
      step(2);
      check("lit_boot_state", 32'(bus.State), 32'd0);
      check("lit_boot_valid", 32'(bus.InstValid), 32'd0);
      check("lit_boot_inst", bus.Inst, 32'h0);
      Reset = 1'b0;
      step();
      check("lit_run_state", 32'(bus.State), 32'd1);
      check("lit_run_pc", bus.PC, 32'h0);
      check("lit_run_inst", bus.Inst, 32'h2001_0008);
      check("lit_run_valid", 32'(bus.InstValid), 32'd1);
      check("lit_run_ret", 32'(bus.RetiredCnt), 32'd0);

      // Stall with branch held
      step(2);
      check("lit_pc8", bus.PC, 32'h08);
      drive(1'b1, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b0);
      step(3);
      check("lit_stall_pc", bus.PC, 32'h08);
      check("lit_stall_ret", 32'(bus.RetiredCnt), 32'd2);
      idle();
      step();
      check("lit_unstall_pc", bus.PC, 32'h0C);
      check("lit_unstall_ret", 32'(bus.RetiredCnt), 32'd3);

      // Branch and jump
      step(3);
      check("lit_pc18", bus.PC, 32'h18);
      drive(1'b0, 1'b1, 16'h0002, 1'b0, 26'h0, 1'b0);
      step();
      check("lit_branch", bus.PC, 32'h24);
      idle();
      step();
      drive(1'b0, 1'b0, 16'h0, 1'b1, 26'h000000D, 1'b0);
      step();
      check("lit_jump", bus.PC, 32'h34);
      idle();
      step(2);
      check("lit_pc3c", bus.PC, 32'h3C);
      drive(1'b0, 1'b1, 16'h0003, 1'b1, 26'h0000013, 1'b0);
      step();
      check("lit_jump_wins", bus.PC, 32'h4C);
      drive(1'b0, 1'b1, 16'hFFFB, 1'b0, 26'h0, 1'b0);
      step();
      check("lit_back_3c", bus.PC, 32'h3C);
      drive(1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0);
      step();
      check("lit_neg_branch", bus.PC, 32'h30);

      // Negative wrap fault
      idle();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      step(2);
      check("lit_pc4", bus.PC, 32'h04);
      drive(1'b0, 1'b1, 16'hFFFD, 1'b0, 26'h0, 1'b0);
      step();
      check("lit_wrap_state", 32'(bus.State), 32'd2);
      check("lit_wrap_fault", 32'(bus.Fault), 32'd1);
      check("lit_wrap_pc", bus.PC, 32'h04);
      check("lit_wrap_ret", 32'(bus.RetiredCnt), 32'd2);

      // Sequential run off the end of the ROM
      idle();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      step();
      step(31);
      check("lit_pc7c", bus.PC, 32'h7C);
      step();
      check("lit_oor_state", 32'(bus.State), 32'd2);
      check("lit_oor_fault", 32'(bus.Fault), 32'd1);
      check("lit_oor_pc", bus.PC, 32'h7C);
      check("lit_oor_valid", 32'(bus.InstValid), 32'd0);
      check("lit_oor_inst", bus.Inst, 32'h0);
      check("lit_oor_ret", 32'(bus.RetiredCnt), 32'd32);
      drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1);
      step();
      check("lit_fault_sticky", 32'(bus.Fault), 32'd1);

      // Halt with stall, then recovery
      idle();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      step();
      step(4);
      check("lit_pc10", bus.PC, 32'h10);
      drive(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1);
      step();
      check("lit_halt_state", 32'(bus.State), 32'd2);
      check("lit_halt_fault", 32'(bus.Fault), 32'd2);
      check("lit_halt_pc", bus.PC, 32'h10);
      check("lit_halt_ret", 32'(bus.RetiredCnt), 32'd4);
      idle();
      Reset = 1'b1;
      step();
      check("lit_rec_state", 32'(bus.State), 32'd0);
      check("lit_rec_fault", 32'(bus.Fault), 32'd0);
      check("lit_rec_pc", bus.PC, 32'h0);
      Reset = 1'b0;

      // Halt during the boot cycle
      drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1);
      step();
      check("lit_boot_halt_state", 32'(bus.State), 32'd2);
      check("lit_boot_halt_fault", 32'(bus.Fault), 32'd2);

      // Randomized traffic against the model
      idle();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         int o;
         o = int'($urandom_range(0, 80)) - 40;
         Reset = ($urandom_range(0, 99) < 2) || (m_mode == 2 && $urandom_range(0, 3) == 0);
         drive($urandom_range(0, 4) == 0,
               $urandom_range(0, 3) == 0,
               16'(o),
               $urandom_range(0, 7) == 0,
               26'($urandom_range(0, 40)),
               $urandom_range(0, 49) == 0);
         step();
      end
      Reset = 1'b0;
      idle();
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
